// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with multi-beat reduce.
// One output register behind a valid/ready handshake.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic [CNT_W-1:0] beats_o,
    output logic             err_o
);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       acc_op_q, acc_op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic             valid_q, valid_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] op_res, fold_res;
    logic             accept, consume, is_acc, is_ill;

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign accept      = in_valid_i & in_ready_o;
    assign consume     = valid_q & out_ready_i;
    assign is_acc      = (op_i >= 4'd8) && (op_i <= 4'd10);
    assign is_ill      = (op_i > 4'd10);
    assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    assign out_valid_o = valid_q;
    assign result_o    = res_q;
    assign zero_o      = zero_q;
    assign beats_o     = beats_q;
    assign err_o       = err_q;

    // Two-operand bitwise result for single-beat ops; illegal ops give zero.
    always_comb begin
        op_res = '0;
        case (op_i)
            4'd0: op_res = a_i & b_i;
            4'd1: op_res = a_i | b_i;
            4'd2: op_res = a_i ^ b_i;
            4'd3: op_res = ~(a_i | b_i);
            4'd4: op_res = a_i & ~b_i;
            4'd5: op_res = a_i | ~b_i;
            4'd6: op_res = ~(a_i ^ b_i);
            4'd7: op_res = a_i;
            default: op_res = '0;
        endcase
    end

    // Fold the incoming beat into the accumulator with the latched op.
    always_comb begin
        fold_res = acc_q;
        case (acc_op_q)
            4'd8:  fold_res = acc_q & a_i;
            4'd9:  fold_res = acc_q | a_i;
            4'd10: fold_res = acc_q ^ a_i;
            default: fold_res = acc_q;
        endcase
    end

    // Next-state and output-register update for the IDLE/ACCUM controller.
    always_comb begin
        state_d  = state_q;
        acc_op_d = acc_op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        valid_d  = consume ? 1'b0 : valid_q;
        res_d    = res_q;
        beats_d  = beats_q;
        err_d    = err_q;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (is_acc) begin
                        acc_op_d = op_i;
                        acc_d    = a_i;
                        cnt_d    = CNT_W'(1);
                        if (last_i) begin
                            valid_d = 1'b1;
                            res_d   = a_i;
                            beats_d = CNT_W'(1);
                            err_d   = 1'b0;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        valid_d = 1'b1;
                        res_d   = op_res;
                        beats_d = CNT_W'(1);
                        err_d   = is_ill;
                    end
                end
                ACCUM: begin
                    acc_d = fold_res;
                    cnt_d = cnt_inc;
                    if (last_i) begin
                        valid_d = 1'b1;
                        res_d   = fold_res;
                        beats_d = cnt_inc;
                        err_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            endcase
        end
        zero_d = (res_d == '0);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            acc_op_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            res_q    <= '0;
            zero_q   <= 1'b1;
            beats_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_op_q <= acc_op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            beats_q  <= beats_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed self-checking bench for logic_unit_pipe.
// Two instances: default widths and CNT_W=2 for counter saturation.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_valid2;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        last;
    logic        out_ready;

    logic        in_ready, out_valid, zero, err;
    logic [31:0] result;
    logic [7:0]  beats;

    logic        in_ready2, out_valid2, zero2, err2;
    logic [31:0] result2;
    logic [1:0]  beats2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(32), .CNT_W(8)) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .last_i     (last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .zero_o     (zero),
        .beats_o    (beats),
        .err_o      (err)
    );

    logic_unit_pipe #(.WIDTH(32), .CNT_W(2)) u_sat (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid2),
        .in_ready_o (in_ready2),
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .last_i     (last),
        .out_valid_o(out_valid2),
        .out_ready_i(out_ready),
        .result_o   (result2),
        .zero_o     (zero2),
        .beats_o    (beats2),
        .err_o      (err2)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one beat to the selected instance for one edge.
    task automatic send(input int sel, input logic [3:0] o,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic l);
        op = o;
        a = va;
        b = vb;
        last = l;
        if (sel == 0) in_valid = 1'b1;
        else in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_tab [8];

    initial begin
        exp_tab[0] = 32'h00F0_00FF;
        exp_tab[1] = 32'hFFF0_FFFF;
        exp_tab[2] = 32'hFF00_FF00;
        exp_tab[3] = 32'h000F_0000;
        exp_tab[4] = 32'hF000_FF00;
        exp_tab[5] = 32'hF0FF_FFFF;
        exp_tab[6] = 32'h00FF_00FF;
        exp_tab[7] = 32'hF0F0_FFFF;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        chk("rst_valid", out_valid, 0);
        chk("rst_zero", zero, 1);
        chk("rst_ready", in_ready, 1);
        chk("rst_result", result, 0);
        chk("rst_beats", beats, 0);
        chk("rst_err", err, 0);

        // Single ops back-to-back, throughput 1/cycle.
        for (int i = 0; i < 8; i++) begin
            send(0, 4'(i), 32'hF0F0_FFFF, 32'h0FF0_00FF, 1'b0);
            chk($sformatf("op%0d_result", i), result, exp_tab[i]);
            chk($sformatf("op%0d_valid", i), out_valid, 1);
            chk($sformatf("op%0d_zero", i), zero, 0);
            chk($sformatf("op%0d_beats", i), beats, 1);
            chk($sformatf("op%0d_err", i), err, 0);
        end
        idle();
        chk("drain_valid", out_valid, 0);

        // ACC_XOR burst; op_i on later beats is ignored.
        send(0, 4'd10, 32'h1, 32'h0, 1'b0);
        chk("xor_b1_valid", out_valid, 0);
        send(0, 4'd0, 32'h3, 32'h0, 1'b0);
        chk("xor_b2_valid", out_valid, 0);
        send(0, 4'd5, 32'h4, 32'h0, 1'b1);
        chk("xor_valid", out_valid, 1);
        chk("xor_result", result, 32'h6);
        chk("xor_beats", beats, 3);
        idle();
        chk("xor_drain", out_valid, 0);

        // Single-beat accumulate burst.
        send(0, 4'd9, 32'h0000_0000, 32'h0, 1'b1);
        chk("acc1_result", result, 0);
        chk("acc1_zero", zero, 1);
        chk("acc1_beats", beats, 1);
        idle();

        // Backpressure hold, then same-cycle consume and accept.
        out_ready = 1'b0;
        send(0, 4'd7, 32'hA5, 32'h0, 1'b0);
        chk("bp_result0", result, 32'hA5);
        for (int i = 0; i < 5; i++) begin
            send(0, 4'd7, 32'h1234, 32'h0, 1'b0);
            chk($sformatf("bp_ready%0d", i), in_ready, 0);
            chk($sformatf("bp_valid%0d", i), out_valid, 1);
            chk($sformatf("bp_hold%0d", i), result, 32'hA5);
        end
        out_ready = 1'b1;
        op = 4'd7;
        a = 32'h5A;
        in_valid = 1'b1;
        #1;
        chk("bp_ready_up", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_result", result, 32'h5A);
        chk("bp_next_valid", out_valid, 1);
        idle();
        chk("bp_drain", out_valid, 0);

        // Illegal op then recovery.
        send(0, 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("ill_result", result, 0);
        chk("ill_err", err, 1);
        chk("ill_zero", zero, 1);
        chk("ill_beats", beats, 1);
        send(0, 4'd0, 32'h0F, 32'hFF, 1'b0);
        chk("ill_clr_err", err, 0);
        chk("ill_clr_result", result, 32'h0F);
        idle();

        // Reset mid-burst discards the partial accumulation.
        send(0, 4'd9, 32'hF0, 32'h0, 1'b0);
        send(0, 4'd9, 32'h100, 32'h0, 1'b0);
        rst_n = 1'b0;
        #3;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_zero", zero, 1);
        idle();
        rst_n = 1'b1;
        idle();
        send(0, 4'd9, 32'h0F, 32'h0, 1'b0);
        chk("fresh_b1_valid", out_valid, 0);
        send(0, 4'd9, 32'h30, 32'h0, 1'b1);
        chk("fresh_result", result, 32'h3F);
        chk("fresh_beats", beats, 2);
        idle();

        // CNT_W=2 saturation over a 6-beat ACC_AND burst.
        for (int i = 0; i < 6; i++) begin
            send(1, 4'd8, 32'hFFFF_FFFF, 32'h0, (i == 5));
            if (i < 5) chk($sformatf("sat_b%0d_valid", i), out_valid2, 0);
        end
        chk("sat_valid", out_valid2, 1);
        chk("sat_beats", beats2, 3);
        chk("sat_result", result2, 32'hFFFF_FFFF);
        idle();

        // Accumulation stays correct past saturation.
        for (int i = 0; i < 5; i++) begin
            send(1, 4'd10, 32'h1 << i, 32'h0, (i == 4));
        end
        chk("sat2_result", result2, 32'h1F);
        chk("sat2_beats", beats2, 3);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
